quadrature_generator: RTL and testbench
=======================================

# quadrature_generator

Synthesizes quadrature encoder phase signals (A/B) from signed step commands, producing the same waveform a physical rotary encoder drives into the board. It is the transmit-side counterpart to the on-chip quadrature decoder: it serves as a stimulus source for closed-loop self-test (looped back to the decoder inputs) and as a step/direction-style output for driving external quadrature consumers. A running signed position count is kept that, under loopback, must equal the decoder's count.

## Interface
- WIDTH, 16: width of step command and position count.
- PERIOD_W, 16: width of edge-period field.
- COUNTS_PER_REV, 96: edges per revolution; used only by the index feature.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_steps  in  WIDTH  signed edge count; sign selects direction; magnitude = number of phase edges.
- cmd_period  in  PERIOD_W  clocks between edges; 0 treated as 1.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high in IDLE; command accepted on a rising edge with cmd_valid & cmd_ready.
- abort  in  1  terminate the active command.
- encoder1  out  1  phase A, registered.
- encoder2  out  1  phase B, registered.
- position  out  WIDTH  signed running edge count, registered.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.
- index  out  1  present only with QGEN_INDEX_EN.

## Operation
- FSM states IDLE, RUN. Reset → IDLE.
- Phase sequence (A,B), forward: 00→10→11→01→00 (A leads B). Reverse: the exact inverse, 00→01→11→10→00. One step = one transition.
- Each forward edge: position +1. Each reverse edge: position −1. Two's-complement wrap (32767+1 → −32768); no saturation.
- IDLE, accept with cmd_steps ≠ 0: latch dir = sign, remaining = |cmd_steps| in WIDTH+1 bits (−32768 yields 32768 edges), period = max(cmd_period,1), then → RUN.
- IDLE, accept with cmd_steps = 0: no edges; done pulses the next cycle; stay IDLE.
- RUN: cmd_valid is ignored (cmd_ready = 0). When the timer expires, emit one edge and decrement remaining. On the final edge → IDLE with done.
- abort in RUN: → IDLE on the next edge, with no done pulse. Phase and position hold their current values. abort has priority over an edge due that same cycle, so no edge is emitted. abort in IDLE is ignored.
- Phase and position persist across commands; a new command continues from the current phase.

## Timing
- Reset values: encoder1 = 0, encoder2 = 0, position = 0, busy = 0, done = 0, cmd_ready = 1 (combinational from IDLE), index = 1 (with the macro).
- Command accepted at rising edge k with N edges and period P: edge n is visible on the outputs after rising edge k + n·P, for n = 1..N.
- done and the return of cmd_ready coincide with edge N (after rising edge k + N·P). The earliest next accept is rising edge k + N·P + 1.
- position updates in the same cycle as its phase edge.
- rst asserted mid-RUN: all state returns to reset values on that edge; the command is discarded with no done.

## Configuration
- QGEN_INDEX_EN defined:
  - Adds the index output and a revolution counter rev_cnt in 0..COUNTS_PER_REV−1.
  - rev_cnt increments on forward edges and decrements on reverse edges, wrapping in both directions.
  - index = (rev_cnt == 0), registered with the phase outputs.
  - rev_cnt resets to 0 on rst.
- QGEN_INDEX_EN undefined: no index port and no counter logic. All other behaviour is identical.

## Test plan
- Reset/basic forward: after rst, A/B = 00, position = 0, cmd_ready = 1. Accept steps = 8, period = 4 at edge k.
  - A/B = 10, 11, 01, 00, 10, 11, 01, 00 after edges k+4 … k+32.
  - position = 8.
  - done high only in the cycle after k+32.
  - busy high from k+1 through k+31.
- Reverse / minimum period: from A/B = 00, steps = −3, period = 0. A/B = 01, 11, 10 on three consecutive cycles; position = −3; done with the third edge.
- Zero/ignored commands: steps = 0 gives done the next cycle with no A/B change. A cmd_valid held during RUN is not accepted until cmd_ready returns.
- Wrap/extreme magnitude: steps = 32767 then steps = 1 (period 1) ends with position = −32768. Then steps = −32768 emits exactly 32768 edges and ends with position = 0.
- Abort/reset mid-run: steps = 10, period 2, abort after the 3rd edge → position = 3, no done, cmd_ready = 1 the next cycle. Repeating with rst instead → all outputs return to reset values.
- Index (QGEN_INDEX_EN, COUNTS_PER_REV = 4):
  - index = 1 after reset; 0 during edges 1–3; 1 at edge 4 of a forward 4-step command.
  - A reverse 1-step from rev_cnt = 0 gives rev_cnt = 3 and index = 0.

Source files
------------

// File: rtl/quadrature_generator.sv
// quadrature_generator: turns signed step commands into A/B quadrature phase
// edges with a running signed position count. Build option QGEN_INDEX_EN adds
// a once-per-revolution index output driven by a wrapping revolution counter.
module quadrature_generator #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned PERIOD_W       = 16,
    parameter int unsigned COUNTS_PER_REV = 96
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [WIDTH-1:0]    cmd_steps,
    input  logic        [PERIOD_W-1:0] cmd_period,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       abort,
    output logic                       encoder1,
    output logic                       encoder2,
    output logic signed [WIDTH-1:0]    position,
    output logic                       busy,
    output logic                       done
`ifdef QGEN_INDEX_EN
    ,
    output logic                       index
`endif
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e              state_q, state_d;
    logic                dir_q, dir_d;           // 1 = reverse
    logic [WIDTH:0]      rem_q, rem_d;           // one extra bit so -2^(W-1) fits
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic                a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]    pos_q, pos_d;
    logic                done_q, done_d;
    logic                step;

    logic [WIDTH:0]      steps_ext;
    logic [WIDTH:0]      cmd_mag;

    // State register: all sequential state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            period_q <= '0;
            timer_q  <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            pos_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            rem_q    <= rem_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pos_q    <= pos_d;
            done_q   <= done_d;
        end
    end

    // Next-state: command accept, edge timer, phase stepping and position
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rem_d     = rem_q;
        period_d  = period_q;
        timer_d   = timer_q;
        a_d       = a_q;
        b_d       = b_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        step      = 1'b0;
        steps_ext = {cmd_steps[WIDTH-1], cmd_steps};
        cmd_mag   = cmd_steps[WIDTH-1] ? -steps_ext : steps_ext;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        dir_d    = cmd_steps[WIDTH-1];
                        rem_d    = cmd_mag;
                        period_d = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
                        // timer counts down to zero; first edge lands period clocks after accept
                        timer_d  = period_d - PERIOD_W'(1);
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    step    = 1'b1;
                    timer_d = period_q - PERIOD_W'(1);
                    rem_d   = rem_q - (WIDTH+1)'(1);
                    if (rem_q == (WIDTH+1)'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - PERIOD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // forward 00->10->11->01, reverse is the exact inverse
        if (step) begin
            if (dir_q) begin
                a_d   = b_q;
                b_d   = ~a_q;
                pos_d = pos_q - WIDTH'(1);
            end else begin
                a_d   = ~b_q;
                b_d   = a_q;
                pos_d = pos_q + WIDTH'(1);
            end
        end
    end

    // Outputs: handshake/status decoded from state, phases from registers
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q == S_RUN);
        encoder1  = a_q;
        encoder2  = b_q;
        position  = pos_q;
        done      = done_q;
    end

`ifdef QGEN_INDEX_EN
    localparam int unsigned REV_W = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;

    logic [REV_W-1:0] rev_q, rev_d;

    // Revolution counter register
    always_ff @(posedge clk) begin
        if (rst) rev_q <= '0;
        else     rev_q <= rev_d;
    end

    // Revolution counter wraps in both directions alongside each phase edge
    always_comb begin
        rev_d = rev_q;
        if (step) begin
            if (dir_q) rev_d = (rev_q == '0) ? REV_W'(COUNTS_PER_REV - 1) : rev_q - REV_W'(1);
            else       rev_d = (rev_q == REV_W'(COUNTS_PER_REV - 1)) ? '0 : rev_q + REV_W'(1);
        end
    end

    // Index marks revolution position zero
    always_comb begin
        index = (rev_q == '0);
    end
`else
    logic unused_cpr;
    assign unused_cpr = (COUNTS_PER_REV == 0);
`endif

endmodule

// File: tb/tb_quadrature_generator.sv
// Testbench for quadrature_generator: directed table, reset/abort sequences
// and randomized commands against an edge-count reference model.
module tb_quadrature_generator;

    localparam int W   = 16;
    localparam int PW  = 16;
    localparam int CPR = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [W-1:0]  cmd_steps;
    logic        [PW-1:0] cmd_period;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 abort;
    logic                 encoder1, encoder2;
    logic signed [W-1:0]  position;
    logic                 busy, done;
`ifdef QGEN_INDEX_EN
    logic                 index;
`endif

    quadrature_generator #(
        .WIDTH(W),
        .PERIOD_W(PW),
        .COUNTS_PER_REV(CPR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_steps(cmd_steps),
        .cmd_period(cmd_period),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .abort(abort),
        .encoder1(encoder1),
        .encoder2(encoder2),
        .position(position),
        .busy(busy),
        .done(done)
`ifdef QGEN_INDEX_EN
        ,
        .index(index)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: phase index into {00,10,11,01}, position, revolution
    int m_idx, m_pos, m_rev;

    function automatic void check(string name, int act, int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    endfunction

    function automatic logic [1:0] phase_ab(int idx);
        logic [1:0] ab;
        case (idx)
            0: ab = 2'b00;
            1: ab = 2'b10;
            2: ab = 2'b11;
            default: ab = 2'b01;
        endcase
        return ab;
    endfunction

    function automatic int wrap4(int x);
        return ((x % 4) + 4) % 4;
    endfunction

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_steps = '0; cmd_period = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enc1", int'(encoder1), 0);
        check("rst_enc2", int'(encoder2), 0);
        check("rst_pos", int'(position), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);
`ifdef QGEN_INDEX_EN
        check("rst_index", int'(index), 1);
`endif
        rst = 1'b0;
        m_idx = 0; m_pos = 0; m_rev = 0;
    endtask

    // Offer a command, then compare every cycle (or only the last if !full)
    // against edges expected = min(t/P, N), frozen at an abort.
    task automatic run_cmd(input int steps, input int period, input int abort_at,
                           input bit full, input bit hold);
        int n, p, dir, e, t_end;
        bit bsy, dn;
        logic signed [W-1:0] ep;
        logic [1:0] ab;
        n = (steps < 0) ? -steps : steps;
        p = (period == 0) ? 1 : period;
        dir = (steps < 0) ? -1 : 1;
        t_end = (n == 0) ? 0 : ((abort_at != 0) ? abort_at : n * p);
        cmd_steps = W'(steps);
        cmd_period = PW'(period);
        cmd_valid = 1'b1;
        e = 0;
        for (int t = 0; t <= t_end; t++) begin
            @(posedge clk);
            #1;
            if (t == 0 && !hold) cmd_valid = 1'b0;
            abort = 1'b0;
            if (abort_at != 0 && t >= abort_at) e = (abort_at - 1) / p;
            else e = t / p;
            if (e > n) e = n;
            bsy = (n != 0) && (t < t_end);
            dn = (abort_at == 0) && (t == t_end);
            if (full || t == t_end) begin
                ep = W'(m_pos + dir * e);
                ab = phase_ab(wrap4(m_idx + dir * e));
                check("enc1", int'(encoder1), int'(ab[1]));
                check("enc2", int'(encoder2), int'(ab[0]));
                check("position", int'(position), int'(ep));
                check("busy", int'(busy), int'(bsy));
                check("done", int'(done), int'(dn));
                check("cmd_ready", int'(cmd_ready), int'(!bsy));
`ifdef QGEN_INDEX_EN
                check("index", int'(index), int'(((m_rev + dir * e) % CPR + CPR) % CPR == 0));
`endif
            end
            if (abort_at != 0 && t == abort_at - 1) abort = 1'b1;
        end
        m_idx = wrap4(m_idx + dir * e);
        m_pos = int'(W'(m_pos + dir * e));
        m_rev = ((m_rev + dir * e) % CPR + CPR) % CPR;
    endtask

    typedef struct {
        int         steps;
        int         period;
        int         abort_at;
        bit         full;
        bit         hold;
        bit         pre_rst;
        int         exp_pos;
        logic [1:0] exp_ab;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{8,      4, 0, 1'b1, 1'b0, 1'b1, 8,      2'b00};
        vecs[1] = '{-3,     0, 0, 1'b1, 1'b0, 1'b0, 5,      2'b10};
        vecs[2] = '{0,      5, 0, 1'b1, 1'b0, 1'b0, 5,      2'b10};
        vecs[3] = '{2,      3, 0, 1'b1, 1'b1, 1'b0, 7,      2'b01};
        vecs[4] = '{2,      3, 0, 1'b1, 1'b0, 1'b0, 9,      2'b10};
        vecs[5] = '{10,     2, 7, 1'b1, 1'b0, 1'b0, 12,     2'b00};
        vecs[6] = '{32767,  1, 0, 1'b0, 1'b0, 1'b1, 32767,  2'b01};
        vecs[7] = '{1,      1, 0, 1'b1, 1'b0, 1'b0, -32768, 2'b00};
        vecs[8] = '{-32768, 1, 0, 1'b0, 1'b0, 1'b0, 0,      2'b00};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pre_rst) do_reset();
            run_cmd(vecs[i].steps, vecs[i].period, vecs[i].abort_at, vecs[i].full, vecs[i].hold);
            check($sformatf("vec%0d_pos", i), int'(position), vecs[i].exp_pos);
            check($sformatf("vec%0d_ab", i), int'({encoder1, encoder2}), int'(vecs[i].exp_ab));
        end
        cmd_valid = 1'b0;

        // abort in idle is ignored
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_ready", int'(cmd_ready), 1);
        check("idle_abort_pos", int'(position), m_pos);

        // reset in the middle of a run discards the command
        run_cmd(3, 1, 0, 1, 0);
        cmd_steps = W'(10); cmd_period = PW'(2); cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrun_pos_pre", int'(position), m_pos + 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_enc1", int'(encoder1), 0);
        check("midrst_enc2", int'(encoder2), 0);
        check("midrst_pos", int'(position), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        check("midrst_nodone", int'(done), 0);
        check("midrst_hold", int'(position), 0);
        m_idx = 0; m_pos = 0; m_rev = 0;

`ifdef QGEN_INDEX_EN
        do_reset();
        run_cmd(4, 1, 0, 1, 0);
        check("index_rev_done", int'(index), 1);
        run_cmd(-1, 1, 0, 1, 0);
        check("index_rev_back", int'(index), 0);
`endif

        // randomized commands against the model
        for (int r = 0; r < 40; r++) begin
            int s, pr, ab_at, nn;
            nn = int'($urandom_range(0, 20));
            s = ($urandom_range(0, 1) == 1) ? -nn : nn;
            pr = int'($urandom_range(0, 5));
            ab_at = 0;
            if (nn != 0 && $urandom_range(0, 3) == 0)
                ab_at = int'($urandom_range(1, nn * ((pr == 0) ? 1 : pr)));
            run_cmd(s, pr, ab_at, 1'b1, bit'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("final_pos", int'(position), m_pos);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
